jtag_dtm: RTL
=============

JTAG_DTM -- requirements
Module: jtag_dtm

Interface
REQ-001 SHALL have parameter IDCODE, default 32'h1000_0CFB, value loaded by Capture-DR with IR=IDCODE; bit 0 SHALL be 1.
REQ-002 SHALL have parameter ABITS, default 7, DMI address width, fixed to match dmi_addr[8:2].
REQ-003 SHALL have port clk  input  1  the single system clock; all state changes on rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port jtag_tck  input  1  JTAG clock, asynchronous, oversampled by clk.
REQ-006 SHALL have port jtag_tms  input  1  JTAG mode select.
REQ-007 SHALL have port jtag_tdi  input  1  JTAG serial data in.
REQ-008 SHALL have port jtag_tdo  output  1  JTAG serial data out, registered.
REQ-009 SHALL have port dmi_valid  output  1  DMI request valid.
REQ-010 SHALL have port dmi_ready  input  1  DMI request accepted; transfer when dmi_valid && dmi_ready.
REQ-011 SHALL have port dmi_write  output  1  1=write, 0=read.
REQ-012 SHALL have port dmi_addr  output  [8:2]  DM register word address.
REQ-013 SHALL have port dmi_wdata  output  32  write data.
REQ-014 SHALL have port dmi_rdata  input  32  read data, valid in the transfer cycle.

Function
REQ-015 SHALL pass tck/tms/tdi through two-flop synchronizers; tck rise/fall events SHALL come from the synchronized tck vs. its one-cycle-delayed copy.
REQ-016 SHALL require tck high and low phases of at least 3 clk cycles each; shorter phases are unsupported.
REQ-017 SHALL implement the 16-state IEEE 1149.1 TAP FSM, advancing only on a tck rise event, using synchronized tms.
REQ-018 SHALL hold a 5-bit IR: Capture-IR loads 5'b00001, Shift-IR shifts LSB-first from tdi, Update-IR commits; Test-Logic-Reset sets IR=5'h01.
REQ-019 SHALL decode IR: 5'h01 IDCODE (32b), 5'h10 DTMCS (32b), 5'h11 DMI (41b), all others BYPASS (1b, captures 0).
REQ-020 SHALL read DTMCS as {14'h0, dmihardreset=0, dmireset=0, 1'b0, idle=3'd1, dmistat[1:0], abits=6'd7, version=4'h1}.
REQ-021 SHALL, on Update-DR with IR=DTMCS, clear sticky dmistat when bit16=1; bit17=1 SHALL clear dmistat, drop dmi_valid and discard any outstanding request.
REQ-022 SHALL format the DMI register as [40:34] addr, [33:2] data, [1:0] op; op 0=nop, 1=read, 2=write, 3=reserved (treated as nop).
REQ-023 SHALL, on Capture-DR with IR=DMI, load {last_addr, last_data, status}; status = dmistat if sticky nonzero, else 3 if a request is outstanding, else 0.
REQ-024 SHALL, on Update-DR with IR=DMI and op 1/2: if a request is outstanding, set dmistat=3 and drop the new op; else if dmistat!=0, drop the op; else launch a request.
REQ-025 SHALL assert dmi_valid in the clk cycle after the Update-DR tck rise event, with dmi_addr/dmi_write/dmi_wdata stable until transfer.
REQ-026 SHALL deassert dmi_valid in the cycle after transfer; it SHALL never assert for two back-to-back requests without a deasserted cycle.
REQ-027 SHALL, in the transfer cycle of a read, latch dmi_rdata into last_data; on write, last_data SHALL hold the written value; last_addr SHALL hold the request address.
REQ-028 SHALL shift every DR LSB-first: Shift-DR shifts tdi into the MSB on each tck rise.
REQ-029 SHALL update jtag_tdo on a tck fall event to shift-register bit 0 (IR in Shift-IR, selected DR in Shift-DR), else hold 0.
REQ-030 SHALL let an in-flight DMI request complete regardless of TAP state changes, including Test-Logic-Reset; only dmihardreset or resetn abort it.

Reset
REQ-031 SHALL, while resetn=0, force TAP=Test-Logic-Reset, IR=5'h01, jtag_tdo=0, dmi_valid=0, dmi_write=0, dmi_addr=0, dmi_wdata=0, dmistat=0, last_addr=0, last_data=0, synchronizers=0.
REQ-032 SHALL, on reset mid-transfer, drop dmi_valid immediately and lose the request.

Verification
REQ-033 Reset, shift 32 DR bits with IR default -> tdo stream = 32'h1000_0CFB LSB-first.
REQ-034 IR=5'h10, shift DR -> 32'h0000_1071.
REQ-035 IR=5'h11, shift {7'h10, 32'h1, 2'd2}; DM ready 1 cycle after valid -> one transfer with write=1, addr=7'h10, wdata=1; next capture op=0.
REQ-036 DMI read op addr 7'h11, dmi_rdata=32'h0003_0382 at transfer -> next capture data=32'h0003_0382, op=0.
REQ-037 dmi_ready held 0, second DMI write issued -> capture op=3, DTMCS dmistat=3, no second transfer; write DTMCS bit16=1 -> dmistat=0.
REQ-038 Five tck with tms=1 from Shift-DR -> Test-Logic-Reset, IR=5'h01; pending request still completes.

Source files
------------

// File: rtl/jtag_dtm.sv
// rtl/jtag_dtm.sv - JTAG debug transport module: oversampled TAP bridged to a DMI request port
// Ports: clk, resetn         system clock, asynchronous active-low reset
//        jtag_tck/tms/tdi   JTAG pins, sampled by clk through two-flop synchronizers
//        jtag_tdo           registered serial out, updated on tck fall events
//        dmi_valid/ready    single-outstanding request handshake (transfer when both high)
//        dmi_write/addr/wdata request fields, dmi_rdata read data in the transfer cycle
module jtag_dtm #(
   parameter logic [31:0] IDCODE = 32'h1000_0CFB,
   parameter int unsigned ABITS  = 7
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        jtag_tck,
   input  logic        jtag_tms,
   input  logic        jtag_tdi,
   output logic        jtag_tdo,
   output logic        dmi_valid,
   input  logic        dmi_ready,
   output logic        dmi_write,
   output logic [8:2]  dmi_addr,
   output logic [31:0] dmi_wdata,
   input  logic [31:0] dmi_rdata
);

   typedef enum logic [3:0] {
      TLR, RTI, SEL_DR, CAP_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPD_DR,
      SEL_IR, CAP_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPD_IR
   } tap_e;

   localparam logic [4:0] IR_IDCODE = 5'h01;
   localparam logic [4:0] IR_DTMCS  = 5'h10;
   localparam logic [4:0] IR_DMI    = 5'h11;

   logic [1:0]  tck_sync_q, tck_sync_d, tms_sync_q, tms_sync_d, tdi_sync_q, tdi_sync_d;
   logic        tck_dly_q, tck_dly_d;
   tap_e        tap_q, tap_d, tap_next;
   logic [4:0]  ir_q, ir_d, ir_sr_q, ir_sr_d;
   logic [40:0] dr_q, dr_d;
   logic        tdo_q, tdo_d;
   logic [1:0]  dmistat_q, dmistat_d;
   logic        dmi_valid_q, dmi_valid_d, dmi_write_q, dmi_write_d;
   logic [6:0]  dmi_addr_q, dmi_addr_d, last_addr_q, last_addr_d;
   logic [31:0] dmi_wdata_q, dmi_wdata_d, last_data_q, last_data_d;

   logic        tck_rise, tck_fall, tms, tdi;
   logic [31:0] dtmcs_val;
   logic [1:0]  dmi_status;

   assign tck_rise   = tck_sync_q[1] & ~tck_dly_q;
   assign tck_fall   = ~tck_sync_q[1] & tck_dly_q;
   assign tms        = tms_sync_q[1];
   assign tdi        = tdi_sync_q[1];
   assign dtmcs_val  = {14'h0, 3'b000, 3'd1, dmistat_q, 6'(ABITS), 4'h1};
   // Sticky error wins over busy so the debugger sees the cause first.
   assign dmi_status = (dmistat_q != 2'd0) ? dmistat_q : (dmi_valid_q ? 2'd3 : 2'd0);

   assign jtag_tdo  = tdo_q;
   assign dmi_valid = dmi_valid_q;
   assign dmi_write = dmi_write_q;
   assign dmi_addr  = dmi_addr_q;
   assign dmi_wdata = dmi_wdata_q;

   always_comb begin
      tap_next = tap_q;
      case (tap_q)
         TLR:      tap_next = tms ? TLR      : RTI;
         RTI:      tap_next = tms ? SEL_DR   : RTI;
         SEL_DR:   tap_next = tms ? SEL_IR   : CAP_DR;
         CAP_DR:   tap_next = tms ? EXIT1_DR : SHIFT_DR;
         SHIFT_DR: tap_next = tms ? EXIT1_DR : SHIFT_DR;
         EXIT1_DR: tap_next = tms ? UPD_DR   : PAUSE_DR;
         PAUSE_DR: tap_next = tms ? EXIT2_DR : PAUSE_DR;
         EXIT2_DR: tap_next = tms ? UPD_DR   : SHIFT_DR;
         UPD_DR:   tap_next = tms ? SEL_DR   : RTI;
         SEL_IR:   tap_next = tms ? TLR      : CAP_IR;
         CAP_IR:   tap_next = tms ? EXIT1_IR : SHIFT_IR;
         SHIFT_IR: tap_next = tms ? EXIT1_IR : SHIFT_IR;
         EXIT1_IR: tap_next = tms ? UPD_IR   : PAUSE_IR;
         PAUSE_IR: tap_next = tms ? EXIT2_IR : PAUSE_IR;
         EXIT2_IR: tap_next = tms ? UPD_IR   : SHIFT_IR;
         UPD_IR:   tap_next = tms ? SEL_DR   : RTI;
      endcase
   end

   always_comb begin
      tck_sync_d  = {tck_sync_q[0], jtag_tck};
      tms_sync_d  = {tms_sync_q[0], jtag_tms};
      tdi_sync_d  = {tdi_sync_q[0], jtag_tdi};
      tck_dly_d   = tck_sync_q[1];
      tap_d       = tck_rise ? tap_next : tap_q;
      ir_d        = ir_q;
      ir_sr_d     = ir_sr_q;
      dr_d        = dr_q;
      tdo_d       = tdo_q;
      dmistat_d   = dmistat_q;
      dmi_valid_d = dmi_valid_q;
      dmi_write_d = dmi_write_q;
      dmi_addr_d  = dmi_addr_q;
      dmi_wdata_d = dmi_wdata_q;
      last_addr_d = last_addr_q;
      last_data_d = last_data_q;

      // Request completion is independent of the TAP so a scan never strands a transfer.
      if (dmi_valid_q && dmi_ready) begin
         dmi_valid_d = 1'b0;
         last_addr_d = dmi_addr_q;
         last_data_d = dmi_write_q ? dmi_wdata_q : dmi_rdata;
      end

      if (tck_fall) begin
         if (tap_q == SHIFT_IR)      tdo_d = ir_sr_q[0];
         else if (tap_q == SHIFT_DR) tdo_d = dr_q[0];
         else                        tdo_d = 1'b0;
      end

      // All TAP actions use the state held during the rising tck event.
      if (tck_rise) begin
         case (tap_q)
            CAP_IR:   ir_sr_d = 5'b00001;
            SHIFT_IR: ir_sr_d = {tdi, ir_sr_q[4:1]};
            UPD_IR:   ir_d    = ir_sr_q;
            CAP_DR: begin
               case (ir_q)
                  IR_IDCODE: dr_d = {9'h0, IDCODE};
                  IR_DTMCS:  dr_d = {9'h0, dtmcs_val};
                  IR_DMI:    dr_d = {last_addr_q, last_data_q, dmi_status};
                  default:   dr_d = '0;
               endcase
            end
            SHIFT_DR: begin
               // Each register is shifted at its own length; tdi enters its MSB.
               dr_d = {1'b0, dr_q[40:1]};
               case (ir_q)
                  IR_IDCODE, IR_DTMCS: dr_d[31] = tdi;
                  IR_DMI:              dr_d[40] = tdi;
                  default:             dr_d[0]  = tdi;
               endcase
            end
            UPD_DR: begin
               if (ir_q == IR_DTMCS) begin
                  if (dr_q[17]) begin
                     dmistat_d   = 2'd0;
                     dmi_valid_d = 1'b0;
                  end else if (dr_q[16]) begin
                     dmistat_d = 2'd0;
                  end
               end else if (ir_q == IR_DMI && (dr_q[1:0] == 2'd1 || dr_q[1:0] == 2'd2)) begin
                  if (dmi_valid_q) begin
                     dmistat_d = 2'd3;
                  end else if (dmistat_q == 2'd0) begin
                     dmi_valid_d = 1'b1;
                     dmi_write_d = (dr_q[1:0] == 2'd2);
                     dmi_addr_d  = dr_q[40:34];
                     dmi_wdata_d = dr_q[33:2];
                  end
               end
            end
            default: ;
         endcase
      end

      if (tap_q == TLR) ir_d = IR_IDCODE;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         tck_sync_q  <= '0;
         tms_sync_q  <= '0;
         tdi_sync_q  <= '0;
         tck_dly_q   <= 1'b0;
         tap_q       <= TLR;
         ir_q        <= IR_IDCODE;
         ir_sr_q     <= '0;
         dr_q        <= '0;
         tdo_q       <= 1'b0;
         dmistat_q   <= 2'd0;
         dmi_valid_q <= 1'b0;
         dmi_write_q <= 1'b0;
         dmi_addr_q  <= '0;
         dmi_wdata_q <= '0;
         last_addr_q <= '0;
         last_data_q <= '0;
      end else begin
         tck_sync_q  <= tck_sync_d;
         tms_sync_q  <= tms_sync_d;
         tdi_sync_q  <= tdi_sync_d;
         tck_dly_q   <= tck_dly_d;
         tap_q       <= tap_d;
         ir_q        <= ir_d;
         ir_sr_q     <= ir_sr_d;
         dr_q        <= dr_d;
         tdo_q       <= tdo_d;
         dmistat_q   <= dmistat_d;
         dmi_valid_q <= dmi_valid_d;
         dmi_write_q <= dmi_write_d;
         dmi_addr_q  <= dmi_addr_d;
         dmi_wdata_q <= dmi_wdata_d;
         last_addr_q <= last_addr_d;
         last_data_q <= last_data_d;
      end
   end

endmodule
